// File: rtl/starvation_aware_arbiter_pkg.sv
// Shared types and helpers for the starvation-aware round-robin arbiter.
package starvation_aware_arbiter_pkg;

  // Output stage occupancy: EMPTY drives request_valid_out low, FULL drives it high.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a requester index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/starvation_aware_arbiter_round_robin_picker.sv
// Combinational round-robin search: the first set bit of mask_i, starting
// at position base_i and wrapping from NUM_REQUEST-1 back to 0.
module round_robin_picker
  import starvation_aware_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 4,
  parameter int IDX_W       = idx_width(NUM_REQUEST)
) (
  input  logic [NUM_REQUEST-1:0] mask_i,
  input  logic [IDX_W-1:0]       base_i,
  output logic [IDX_W-1:0]       index_o,
  output logic                   found_o
);

  logic [31:0] pos;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    index_o = '0;
    pos     = '0;
    found_o = |mask_i;
    for (int unsigned k = NUM_REQUEST; k > 0; k--) begin
      pos = 32'(base_i) + k - 1;
      if (pos >= NUM_REQUEST) begin
        pos = pos - NUM_REQUEST;
      end
      if (mask_i[pos[IDX_W-1:0]]) begin
        index_o = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/starvation_aware_arbiter.sv
// Round-robin arbiter with per-requester age counters. Requesters that have
// waited STARVATION_THRESHOLD cycles are served ahead of normal order. The
// winner is acked combinationally and captured into a registered output
// stage with a valid/ack handshake toward the downstream consumer.
module starvation_aware_arbiter
  import starvation_aware_arbiter_pkg::*;
#(
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int NUM_REQUEST                  = 4,
  parameter int AGE_WIDTH_IN_BITS            = 4,
  parameter int STARVATION_THRESHOLD         = 8
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
  output logic [NUM_REQUEST-1:0]                              issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
  output logic                                                request_valid_out,
  output logic [idx_width(NUM_REQUEST)-1:0]                   request_index_out,
  input  logic                                                issue_ack_in
);

  localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int IDX_W = idx_width(NUM_REQUEST);
  localparam int AW    = AGE_WIDTH_IN_BITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUEST - 1);
  localparam logic [AW-1:0]    AGE_MAX  = '1;
  localparam logic [AW-1:0]    AGE_THR  = AW'(STARVATION_THRESHOLD);

  out_state_e       out_state_q, out_state_d;
  logic [W-1:0]     request_q, request_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [AW-1:0]    age_q [NUM_REQUEST];
  logic [AW-1:0]    age_d [NUM_REQUEST];

  logic [IDX_W-1:0]       base;
  logic [NUM_REQUEST-1:0] starved;
  logic [IDX_W-1:0]       starved_idx, valid_idx, sel;
  logic                   starved_found, valid_found;
  logic                   load_en, grant;
  logic [W-1:0]           payload_sel;

  // Search starts one past the last winner, wrapping at NUM_REQUEST.
  always_comb begin
    base = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + IDX_W'(1);
  end

  // A requester is starved once its age reaches the threshold while still valid.
  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      starved[i] = request_valid_flatted_in[i] && (age_q[i] >= AGE_THR);
    end
  end

  round_robin_picker #(
    .NUM_REQUEST (NUM_REQUEST),
    .IDX_W       (IDX_W)
  ) u_pick_starved (
    .mask_i  (starved),
    .base_i  (base),
    .index_o (starved_idx),
    .found_o (starved_found)
  );

  round_robin_picker #(
    .NUM_REQUEST (NUM_REQUEST),
    .IDX_W       (IDX_W)
  ) u_pick_valid (
    .mask_i  (request_valid_flatted_in),
    .base_i  (base),
    .index_o (valid_idx),
    .found_o (valid_found)
  );

  // Winner selection, one-hot ack and payload mux; nothing is acked during reset.
  always_comb begin
    load_en       = (out_state_q == OUT_EMPTY) || issue_ack_in;
    sel           = starved_found ? starved_idx : valid_idx;
    grant         = load_en && valid_found && !reset_in;
    issue_ack_out = '0;
    payload_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      if (IDX_W'(i) == sel) begin
        issue_ack_out[i] = grant;
        payload_sel      = request_flatted_in[i*W +: W];
      end
    end
  end

  // Output stage next state: load on grant, drain to EMPTY when nothing is valid.
  always_comb begin
    out_state_d  = out_state_q;
    request_d    = request_q;
    index_d      = index_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (valid_found) begin
        out_state_d  = OUT_FULL;
        request_d    = payload_sel;
        index_d      = sel;
        last_grant_d = sel;
      end else begin
        out_state_d = OUT_EMPTY;
      end
    end
  end

  // Age counters: clear on grant or idle, otherwise saturating increment.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      age_d[i] = '0;
      if (grant && (IDX_W'(i) == sel)) begin
        age_d[i] = '0;
      end else if (request_valid_flatted_in[i]) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + AW'(1);
      end
    end
  end

  // State registers with synchronous reset; last_grant resets so the first base is 0.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_state_q  <= OUT_EMPTY;
      request_q    <= '0;
      index_q      <= '0;
      last_grant_q <= LAST_IDX;
      for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      out_state_q  <= out_state_d;
      request_q    <= request_d;
      index_q      <= index_d;
      last_grant_q <= last_grant_d;
      for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign request_out       = request_q;
  assign request_index_out = index_q;
  assign request_valid_out = (out_state_q == OUT_FULL);

endmodule

// File: tb/tb_starvation_aware_arbiter.sv
// Self-checking bench for starvation_aware_arbiter: directed scenarios followed
// by random traffic, all compared against a behavioural reference model.
module tb_starvation_aware_arbiter;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int TH  = 8;
  localparam int IW  = 2;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic [W*N-1:0]   request_flatted_in;
  logic [N-1:0]     request_valid_flatted_in;
  logic [N-1:0]     issue_ack_out;
  logic [W-1:0]     request_out;
  logic             request_valid_out;
  logic [IW-1:0]    request_index_out;
  logic             issue_ack_in;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int           m_age [N];
  int           m_last;
  bit           m_vld;
  logic [W-1:0] m_data;
  int           m_idx;
  logic [W-1:0] pay [N];
  logic [N-1:0] obs_ack;

  always #5 clk_in = ~clk_in;

  starvation_aware_arbiter #(
    .SINGLE_REQUEST_WIDTH_IN_BITS (W),
    .NUM_REQUEST                  (N),
    .AGE_WIDTH_IN_BITS            (AW),
    .STARVATION_THRESHOLD         (TH)
  ) dut (
    .clk_in                   (clk_in),
    .reset_in                 (reset_in),
    .request_flatted_in       (request_flatted_in),
    .request_valid_flatted_in (request_valid_flatted_in),
    .issue_ack_out            (issue_ack_out),
    .request_out              (request_out),
    .request_valid_out        (request_valid_out),
    .request_index_out        (request_index_out),
    .issue_ack_in             (issue_ack_in)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starved requesters first, then any valid one, both in rotation from last+1.
  function automatic int model_pick(input logic [N-1:0] v);
    int base = (m_last + 1) % N;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        int i = (base + k) % N;
        if (v[i] && (pass == 1 || m_age[i] >= TH)) return i;
      end
    end
    return -1;
  endfunction

  // One clock: drive, check ack, advance model, check registered outputs.
  task automatic cycle(input logic [N-1:0] v, input logic ack);
    int           sel;
    logic [N-1:0] exp_ack;
    request_valid_flatted_in = v;
    issue_ack_in             = ack;
    for (int i = 0; i < N; i++) request_flatted_in[i*W +: W] = pay[i];
    #1;
    sel     = (!reset_in && (!m_vld || ack)) ? model_pick(v) : -1;
    exp_ack = (sel >= 0) ? (N'(1) << sel) : '0;
    obs_ack = issue_ack_out;
    chk("issue_ack_out", W'(issue_ack_out), W'(exp_ack));
    @(posedge clk_in);
    if (reset_in) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_idx  = 0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == sel)   m_age[i] = 0;
        else if (v[i])  m_age[i] = (m_age[i] + 1 > AGE_SAT) ? AGE_SAT : m_age[i] + 1;
        else            m_age[i] = 0;
      end
      if (!m_vld || ack) begin
        if (sel >= 0) begin
          m_vld  = 1'b1;
          m_data = pay[sel];
          m_idx  = sel;
          m_last = sel;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
    #1;
    chk("request_valid_out", W'(request_valid_out), W'(m_vld));
    chk("request_index_out", W'(request_index_out), W'(m_idx));
    chk("request_out", request_out, m_data);
    @(negedge clk_in);
  endtask

  initial begin
    int           pulses;
    logic [W-1:0] held;
    for (int i = 0; i < N; i++) pay[i] = {$urandom, $urandom};
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_last = N - 1;
    m_vld  = 1'b0;
    m_data = '0;
    m_idx  = 0;
    reset_in = 1'b1;
    issue_ack_in = 1'b0;
    request_valid_flatted_in = '0;
    request_flatted_in = '0;
    @(negedge clk_in);

    // Reset with all requesters valid: no ack may be issued.
    cycle(4'hF, 1'b1);
    cycle(4'hF, 1'b1);
    chk("reset_valid", W'(request_valid_out), '0);
    reset_in = 1'b0;

    // Round robin with everyone valid and downstream always ready.
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 1'b1);
      chk("rr_grant", W'(obs_ack), W'(N'(1) << (k % N)));
      chk("rr_index_lag", W'(request_index_out), W'(k % N));
    end

    // Downstream stall: one ack pulse, output held stable, then drains.
    pulses = 0;
    cycle(4'b0100, 1'b1);
    pulses += int'(obs_ack[2]);
    held = request_out;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0100, 1'b0);
      pulses += int'(obs_ack[2]);
      chk("stall_hold", request_out, held);
    end
    chk("stall_one_pulse", W'(pulses), W'(1));
    cycle(4'b0100, 1'b1);
    chk("stall_drain_regrant", W'(obs_ack), W'(4'b0100));

    // Starvation at exactly the threshold beats round-robin order from base 0.
    cycle(4'b1000, 1'b1);
    for (int k = 0; k < TH; k++) cycle(4'b1000, 1'b0);
    cycle(4'b1001, 1'b1);
    chk("starve_grant", W'(obs_ack), W'(4'b1000));

    // One cycle short of the threshold: normal order wins.
    for (int k = 0; k < TH - 1; k++) cycle(4'b1000, 1'b0);
    cycle(4'b1001, 1'b1);
    chk("below_threshold", W'(obs_ack), W'(4'b0001));

    // Saturation: a 20-cycle wait must not wrap the age below threshold.
    cycle(4'b1000, 1'b1);
    for (int k = 0; k < 20; k++) cycle(4'b0010, 1'b0);
    cycle(4'b0011, 1'b1);
    chk("saturate_grant", W'(obs_ack), W'(4'b0010));

    // Drop-out: requester 2 withdraws before it could be served.
    for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    chk("dropout_nogrant", W'(obs_ack), '0);
    chk("dropout_empty", W'(request_valid_out), '0);

    // Reset while FULL drops the held request; first grant afterwards is 0.
    cycle(4'b0001, 1'b1);
    reset_in = 1'b1;
    cycle(4'b0001, 1'b1);
    chk("reset_full_valid", W'(request_valid_out), '0);
    chk("reset_full_data", request_out, '0);
    reset_in = 1'b0;
    cycle(4'b0011, 1'b1);
    chk("post_reset_first", W'(obs_ack), W'(4'b0001));

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) pay[i] = {$urandom, $urandom};
      reset_in = ($urandom_range(0, 199) == 0);
      cycle(N'($urandom_range(0, 15) & $urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    reset_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
